// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the RV32IM instruction fetch stage.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetchState_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory busywait bus between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if;

  logic [31:0] address;
  logic        read;
  logic [31:0] instruction;
  logic        busywait;

  modport master (output address, read, input instruction, busywait);
  modport slave  (input address, read, output instruction, busywait);

endinterface

// File: rtl/instruction_fetch_unit_if_id_pipeline_register.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes, load captures a fetched slot.
module if_id_pipeline_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pcPlus4,
  input  logic [31:0] i_instruction,
  output logic [31:0] o_ifPc,
  output logic [31:0] o_ifPcPlus4,
  output logic [31:0] o_ifInstruction,
  output logic        o_ifValid
);

  // Flush outranks hold so a redirect can clear a stalled slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ifPc          <= 32'h0;
      o_ifPcPlus4     <= 32'h0;
      o_ifInstruction <= BUBBLE;
      o_ifValid       <= 1'b0;
    end else if (i_flush) begin
      o_ifPc          <= 32'h0;
      o_ifPcPlus4     <= 32'h0;
      o_ifInstruction <= BUBBLE;
      o_ifValid       <= 1'b0;
    end else if (i_load && !i_hold) begin
      o_ifPc          <= i_pc;
      o_ifPcPlus4     <= i_pcPlus4;
      o_ifInstruction <= i_instruction;
      o_ifValid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: PC, busywait fetch FSM, redirect/stall handling, IF/ID register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  instruction_fetch_unit_if.master        imem,
  input  logic                            i_branchTaken,
  input  logic [31:0]                     i_branchTarget,
  input  logic                            i_stall,
  output logic [31:0]                     o_ifPc,
  output logic [31:0]                     o_ifPcPlus4,
  output logic [31:0]                     o_ifInstruction,
  output logic                            o_ifValid
);

  fetchState_e r_state, w_nextState;
  logic [31:0] r_pc, w_nextPc;
  logic [31:0] r_bufPc, w_nextBufPc;
  logic [31:0] r_bufWord, w_nextBufWord;
  logic [31:0] r_pendingPc, w_nextPendingPc;
  logic        w_complete, w_load, w_flush;
  logic [31:0] w_loadPc, w_loadWord;

  // r_pc stays on the in-flight address during DISCARD, keeping the bus stable.
  assign imem.address = r_pc;
  assign imem.read    = rst_n && (r_state != HOLD);
  assign w_complete   = imem.read && !imem.busywait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_bufPc     <= 32'h0;
      r_bufWord   <= 32'h0;
      r_pendingPc <= 32'h0;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPc;
      r_bufPc     <= w_nextBufPc;
      r_bufWord   <= w_nextBufWord;
      r_pendingPc <= w_nextPendingPc;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pc;
    w_nextBufPc     = r_bufPc;
    w_nextBufWord   = r_bufWord;
    w_nextPendingPc = r_pendingPc;
    w_load          = 1'b0;
    w_flush         = 1'b0;
    w_loadPc        = r_pc;
    w_loadWord      = imem.instruction;
    case (r_state)
      FETCH: begin
        if (i_branchTaken) begin
          w_flush = 1'b1;
          if (w_complete) begin
            w_nextPc = i_branchTarget;
          end else begin
            w_nextPendingPc = i_branchTarget;
            w_nextState     = DISCARD;
          end
        end else if (w_complete) begin
          w_nextPc = r_pc + PC_STEP;
          if (i_stall) begin
            w_nextBufPc   = r_pc;
            w_nextBufWord = imem.instruction;
            w_nextState   = HOLD;
          end else begin
            w_load = 1'b1;
          end
        end else if (!i_stall) begin
          w_flush = 1'b1;
        end
      end
      HOLD: begin
        if (i_branchTaken) begin
          w_nextPc      = i_branchTarget;
          w_nextBufPc   = 32'h0;
          w_nextBufWord = 32'h0;
          w_flush       = 1'b1;
          w_nextState   = FETCH;
        end else if (!i_stall) begin
          w_load      = 1'b1;
          w_loadPc    = r_bufPc;
          w_loadWord  = r_bufWord;
          w_nextState = FETCH;
        end
      end
      DISCARD: begin
        // A redirect arriving on the draining edge wins over the older pending target.
        if (i_branchTaken) begin
          w_nextPendingPc = i_branchTarget;
        end
        if (w_complete) begin
          w_nextPc    = i_branchTaken ? i_branchTarget : r_pendingPc;
          w_nextState = FETCH;
        end
        w_flush = i_branchTaken || !i_stall;
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  if_id_pipeline_register u_ifIdReg (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load          (w_load),
    .i_flush         (w_flush),
    .i_hold          (i_stall),
    .i_pc            (w_loadPc),
    .i_pcPlus4       (w_loadPc + PC_STEP),
    .i_instruction   (w_loadWord),
    .o_ifPc          (o_ifPc),
    .o_ifPcPlus4     (o_ifPcPlus4),
    .o_ifInstruction (o_ifInstruction),
    .o_ifValid       (o_ifValid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized bench for instruction_fetch_unit against a queue-based fetch model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } heldSlot_t;

  logic        clk;
  logic        rst_n;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        stall;
  logic [31:0] ifPc, ifPcPlus4, ifInstruction;
  logic        ifValid;

  instruction_fetch_unit_if imemIf ();

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem            (imemIf),
    .i_branchTaken   (branchTaken),
    .i_branchTarget  (branchTarget),
    .i_stall         (stall),
    .o_ifPc          (ifPc),
    .o_ifPcPlus4     (ifPcPlus4),
    .o_ifInstruction (ifInstruction),
    .o_ifValid       (ifValid)
  );

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Model: next address to fetch, at most one buffered slot, and an optional dropped in-flight fetch.
  logic [31:0] mPc;
  heldSlot_t   mBuf[$];
  bit          mDropInflight;
  logic [31:0] mRedirect;
  logic [31:0] eIfPc, eIfPcPlus4, eIfInstr;
  logic        eIfValid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00a0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imemIf.instruction = memWord(imemIf.address);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setBubble();
    eIfPc = 32'h0; eIfPcPlus4 = 32'h0; eIfInstr = BUBBLE; eIfValid = 1'b0;
  endtask

  task automatic modelReset();
    mPc = RESET_PC;
    mBuf.delete();
    mDropInflight = 1'b0;
    mRedirect = 32'h0;
    setBubble();
  endtask

  task automatic checkIfId(input string where);
    checkOutput({where, " if_pc"},       ifPc,          eIfPc);
    checkOutput({where, " if_pc_plus4"}, ifPcPlus4,     eIfPcPlus4);
    checkOutput({where, " if_instr"},    ifInstruction, eIfInstr);
    checkOutput({where, " if_valid"},    {31'h0, ifValid}, {31'h0, eIfValid});
  endtask

  task automatic checkResetState(input string where);
    checkOutput({where, " imem_read"},    {31'h0, imemIf.read}, 32'h0);
    checkOutput({where, " imem_address"}, imemIf.address, RESET_PC);
    checkIfId(where);
  endtask

  // One clock cycle: drive at negedge, check bus before the edge, advance the model, check IF/ID after.
  task automatic applyStimulus(input bit br, input logic [31:0] tgt, input bit st, input bit bw);
    bit          expRead;
    bit          complete;
    logic [31:0] word;
    branchTaken     = br;
    branchTarget    = tgt;
    stall           = st;
    imemIf.busywait = bw;
    #1;
    expRead = (mBuf.size() == 0);
    checkOutput("imem_read",    {31'h0, imemIf.read}, {31'h0, expRead});
    checkOutput("imem_address", imemIf.address, mPc);
    word     = memWord(mPc);
    complete = expRead && !bw;
    @(posedge clk);
    if (mBuf.size() != 0) begin
      if (br) begin
        mBuf.delete();
        mPc = tgt;
        setBubble();
      end else if (!st) begin
        eIfPc = mBuf[0].pc; eIfPcPlus4 = mBuf[0].pc + 32'd4;
        eIfInstr = mBuf[0].word; eIfValid = 1'b1;
        mBuf.delete();
      end
    end else if (mDropInflight) begin
      if (br) mRedirect = tgt;
      if (complete) begin
        mPc = mRedirect;
        mDropInflight = 1'b0;
      end
      if (br || !st) setBubble();
    end else begin
      if (br) begin
        if (complete) mPc = tgt;
        else begin
          mDropInflight = 1'b1;
          mRedirect = tgt;
        end
        setBubble();
      end else if (complete) begin
        if (st) mBuf.push_back('{pc: mPc, word: word});
        else begin
          eIfPc = mPc; eIfPcPlus4 = mPc + 32'd4; eIfInstr = word; eIfValid = 1'b1;
        end
        mPc = mPc + 32'd4;
      end else if (!st) begin
        setBubble();
      end
    end
    #1;
    checkIfId("cycle");
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    branchTaken = 1'b0;
    branchTarget = 32'h0;
    stall = 1'b0;
    imemIf.busywait = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    $display("[TB] zero-wait fetches");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    $display("[TB] busywait at 8");
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    $display("[TB] redirect while fetch at 12 is busy");
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    $display("[TB] stall over completed fetch at 16");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    $display("[TB] redirect during hold");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    $display("[TB] wraparound and unaligned target");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h102, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    $display("[TB] reset mid-busywait at 24");
    applyStimulus(1'b1, 32'h18, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    imemIf.busywait = 1'b1;
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkResetState("async_reset");
    @(negedge clk);
    imemIf.busywait = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      bit          br, st, bw;
      logic [31:0] tgt;
      br  = ($urandom_range(0, 99) < 12);
      st  = ($urandom_range(0, 99) < 25);
      bw  = ($urandom_range(0, 99) < 35);
      tgt = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
      applyStimulus(br, tgt, st, bw);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
